imm_pack: RTL and testbench

//  Inverse of the immediate sign-extender: inserts a 32-bit signed immediate into the I/S/B/J field

---
 rtl/imm_pack.sv | 105 ++++++++++
 tb/tb_imm_pack.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - packs a signed immediate into I/S/B/J instruction fields
// Two-stage valid/ready pipeline with a saturating count of unrepresentable immediates.
module imm_pack #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      base_instr,
  input  logic [31:0]      imm,
  input  logic [1:0]       immsrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  logic        s1_valid;
  logic [31:0] s1_instr;
  logic        s1_err;
  logic        s1_adv;
  logic        s2_adv;
  logic [31:0] packed_instr;
  logic        pack_err;
  logic        err_xfer;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign err_xfer = out_valid && out_ready && out_err;

  // The sign-extension span must be uniform; B/J also need an even offset.
  always_comb begin
    packed_instr = base_instr;
    pack_err     = 1'b0;
    case (immsrc)
      2'b00: begin
        packed_instr[31:20] = imm[11:0];
        pack_err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      2'b01: begin
        packed_instr[31:25] = imm[11:5];
        packed_instr[11:7]  = imm[4:0];
        pack_err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      2'b10: begin
        packed_instr[31]    = imm[12];
        packed_instr[30:25] = imm[10:5];
        packed_instr[11:8]  = imm[4:1];
        packed_instr[7]     = imm[11];
        pack_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      end
      default: begin
        packed_instr[31]    = imm[20];
        packed_instr[30:21] = imm[10:1];
        packed_instr[20]    = imm[11];
        packed_instr[19:12] = imm[19:12];
        pack_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_instr <= 32'd0;
      s1_err   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_instr <= packed_instr;
        s1_err   <= pack_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= s1_instr;
        out_err   <= s1_err;
      end
    end
  end

  // A clear coinciding with a counted transfer keeps that transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= err_xfer ? CNT_W'(1) : '0;
    end else if (err_xfer && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// tb/tb_imm_pack.sv - self-checking bench for imm_pack
// Vector table plus scoreboarded random traffic with stalls, reset and counter corners.
module tb_imm_pack;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready;
  logic [31:0]   base_instr, imm;
  logic [1:0]    immsrc;
  logic          out_valid, out_ready;
  logic [31:0]   out_instr;
  logic          out_err, err_clr;
  logic [CW-1:0] err_count;

  imm_pack #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .base_instr(base_instr), .imm(imm), .immsrc(immsrc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .err_clr(err_clr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [31:0] imm;
    logic [1:0]  src;
    logic        has_exp;
    logic [31:0] exp_instr;
    logic        exp_err;
  } sb_t;

  sb_t  sbq[$];
  sb_t  tbl[13];
  sb_t  idle;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  logic last_oxfer;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic in_range(input logic [31:0] i, input logic [1:0] s);
    int v;
    v = $signed(i);
    case (s)
      2'b00, 2'b01: in_range = (v >= -2048) && (v <= 2047);
      2'b10:        in_range = (v >= -4096) && (v <= 4095) && !i[0];
      default:      in_range = (v >= -(1 << 20)) && (v < (1 << 20)) && !i[0];
    endcase
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] s);
    case (s)
      2'b00:   ext = {{20{w[31]}}, w[31:20]};
      2'b01:   ext = {{20{w[31]}}, w[31:25], w[11:7]};
      2'b10:   ext = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: ext = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] fmask(input logic [1:0] s);
    case (s)
      2'b00:        fmask = 32'hFFF0_0000;
      2'b01, 2'b10: fmask = 32'hFE00_0F80;
      default:      fmask = 32'hFFFF_F000;
    endcase
  endfunction

  function automatic sb_t gen();
    sb_t r;
    int  bl[13];
    bl = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
           (1 << 20) - 2, (1 << 20), -(1 << 20), -(1 << 20) - 2};
    r.base = $urandom;
    r.src  = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0:       r.imm = $urandom;
      1:       r.imm = $urandom_range(0, 8191) - 32'd4096;
      2:       r.imm = $urandom_range(0, (1 << 22) - 1) - 32'd2097152;
      default: r.imm = bl[$urandom_range(0, 12)];
    endcase
    r.has_exp = 1'b0;
    r.exp_instr = 32'd0;
    r.exp_err = 1'b0;
    return r;
  endfunction

  // One cycle: drive after the falling edge, observe just before the rising edge.
  task automatic step(input logic v, input sb_t it, input logic ordy, input logic clr,
                      output logic acc);
    sb_t  e;
    logic e_err;
    logic oxfer;
    @(negedge clk);
    in_valid = v; base_instr = it.base; imm = it.imm; immsrc = it.src;
    out_ready = ordy; err_clr = clr;
    #4;
    chk("err_count", {16'd0, err_count}, exp_cnt);
    acc = in_valid && in_ready;
    if (acc) sbq.push_back(it);
    oxfer = out_valid && out_ready;
    last_oxfer = oxfer;
    e_err = 1'b0;
    if (oxfer) begin
      if (sbq.size() == 0) begin
        chk("unexpected_word", out_instr, 32'hxxxx_xxxx);
      end else begin
        e = sbq.pop_front();
        if (e.has_exp) begin
          e_err = e.exp_err;
          chk("tbl_instr", out_instr, e.exp_instr);
          chk("tbl_err", {31'd0, out_err}, {31'd0, e.exp_err});
        end else begin
          e_err = !in_range(e.imm, e.src);
          chk("rand_err", {31'd0, out_err}, {31'd0, e_err});
          chk("passthru", out_instr & ~fmask(e.src), e.base & ~fmask(e.src));
          if (!e_err) chk("roundtrip", ext(out_instr, e.src), e.imm);
        end
      end
    end
    if (clr) exp_cnt = (oxfer && e_err) ? 1 : 0;
    else if (oxfer && e_err && exp_cnt != (1 << CW) - 1) exp_cnt++;
  endtask

  initial begin
    logic        acc;
    logic [31:0] held;
    int          idx, accepted;
    sb_t         cur;
    logic        pend;

    idle = '{32'd0, 32'd0, 2'd0, 1'b0, 32'd0, 1'b0};
    tbl[0]  = '{32'h0000_0013, 32'hFFFF_FFFF, 2'b00, 1'b1, 32'hFFF0_0013, 1'b0};
    tbl[1]  = '{32'h0000_0063, 32'hFFFF_F000, 2'b10, 1'b1, 32'h8000_0063, 1'b0};
    tbl[2]  = '{32'h0000_0063, 32'h0000_1000, 2'b10, 1'b1, 32'h8000_0063, 1'b1};
    tbl[3]  = '{32'h0000_006F, 32'h0000_0003, 2'b11, 1'b1, 32'h0020_006F, 1'b1};
    tbl[4]  = '{32'h0000_006F, 32'h000F_FFFE, 2'b11, 1'b1, 32'h7FFF_F06F, 1'b0};
    tbl[5]  = '{32'h0000_0023, 32'h0000_07FF, 2'b01, 1'b1, 32'h7E00_0FA3, 1'b0};
    tbl[6]  = '{32'h0000_0023, 32'h0000_0800, 2'b01, 1'b1, 32'h8000_0023, 1'b1};
    tbl[7]  = '{32'h0000_0000, 32'hFFFF_F800, 2'b00, 1'b1, 32'h8000_0000, 1'b0};
    tbl[8]  = '{32'h0000_0000, 32'h0000_0800, 2'b00, 1'b1, 32'h8000_0000, 1'b1};
    tbl[9]  = '{32'h0000_0000, 32'h0000_0FFE, 2'b10, 1'b1, 32'h7E00_0F80, 1'b0};
    tbl[10] = '{32'h0000_0000, 32'h0000_0001, 2'b10, 1'b1, 32'h0000_0000, 1'b1};
    tbl[11] = '{32'h0000_0000, 32'hFFF0_0000, 2'b11, 1'b1, 32'h8000_0000, 1'b0};
    tbl[12] = '{32'hFFFF_FFFF, 32'h0000_0000, 2'b00, 1'b1, 32'h000F_FFFF, 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; base_instr = 32'd0; imm = 32'd0; immsrc = 2'd0;
    out_ready = 1'b0; err_clr = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // latency
    step(1'b1, tbl[0], 1'b1, 1'b0, acc);
    chk("lat_accept", {31'd0, acc}, 32'd1);
    step(1'b0, idle, 1'b1, 1'b0, acc);
    chk("lat_cycle1", {31'd0, out_valid}, 32'd0);
    step(1'b0, idle, 1'b1, 1'b0, acc);
    chk("lat_cycle2", {31'd0, out_valid}, 32'd1);

    // vector table, back to back
    for (int k = 0; k < 13; k++) step(1'b1, tbl[k], 1'b1, 1'b0, acc);
    for (int k = 0; k < 6 && sbq.size() != 0; k++) step(1'b0, idle, 1'b1, 1'b0, acc);
    chk("tbl_drained", sbq.size(), 32'd0);
    chk("tbl_errcnt", {16'd0, err_count}, 32'd5);

    // backpressure: four words offered against a 5-cycle stall
    idx = 0; accepted = 0; held = 32'd0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, tbl[(idx == 0) ? 0 : (idx == 1) ? 5 : (idx == 2) ? 7 : 9], 1'b0, 1'b0, acc);
      if (acc) begin idx++; accepted++; end
      if (k >= 2) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        if (k == 2) held = out_instr;
        else chk("stall_hold", out_instr, held);
      end
    end
    chk("stall_accepted", accepted, 32'd2);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 20 && (idx < 4 || sbq.size() != 0); k++) begin
      step(idx < 4, tbl[(idx == 0) ? 0 : (idx == 1) ? 5 : (idx == 2) ? 7 : 9], 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    chk("release_sent", idx, 32'd4);
    chk("release_drained", sbq.size(), 32'd0);

    // reset with two words in flight
    step(1'b1, tbl[2], 1'b0, 1'b0, acc);
    step(1'b1, tbl[3], 1'b0, 1'b0, acc);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_err_count", {16'd0, err_count}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    sbq.delete();
    exp_cnt = 0;
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, idle, 1'b1, 1'b0, acc);
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end

    // err_clr coinciding with an error transfer
    step(1'b1, tbl[2], 1'b1, 1'b0, acc);
    step(1'b0, idle, 1'b1, 1'b0, acc);
    step(1'b0, idle, 1'b1, 1'b0, acc);
    step(1'b1, tbl[8], 1'b1, 1'b0, acc);
    step(1'b0, idle, 1'b1, 1'b0, acc);
    chk("pre_clr_count", {16'd0, err_count}, 32'd1);
    step(1'b0, idle, 1'b1, 1'b1, acc);
    chk("clr_with_xfer", {31'd0, last_oxfer}, 32'd1);
    step(1'b0, idle, 1'b1, 1'b0, acc);
    chk("clr_count_one", {16'd0, err_count}, 32'd1);
    step(1'b0, idle, 1'b1, 1'b1, acc);
    step(1'b0, idle, 1'b1, 1'b0, acc);
    chk("clr_alone", {16'd0, err_count}, 32'd0);

    // random traffic with stalls and occasional clears
    pend = 1'b0;
    cur = idle;
    for (int n = 0; n < 10000; n++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 3) != 0);
        cur = gen();
      end
      step(pend, cur, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, acc);
      if (acc) pend = 1'b0;
    end
    for (int k = 0; k < 20 && sbq.size() != 0; k++) step(1'b0, idle, 1'b1, 1'b0, acc);
    chk("rand_drained", sbq.size(), 32'd0);
    step(1'b0, idle, 1'b1, 1'b0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
